// File: rtl/comparator_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// comparator_arbiter_pkg
//
// Shared definitions for the comparator arbiter and its strength datapath:
//   strength_t   - 4-bit redstone signal strength (0..15)
//   MODE_*       - per-requester operating mode encoding
//   state_t      - arbiter/sequencer FSM state
//   strength_max - larger of two strengths
// -----------------------------------------------------------------------------
package comparator_arbiter_pkg;

    typedef logic [3:0] strength_t;

    localparam logic MODE_COMPARE  = 1'b0;
    localparam logic MODE_SUBTRACT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic strength_t strength_max(input strength_t a, input strength_t b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/comparator_core.sv
// -----------------------------------------------------------------------------
// comparator_core
//
// Purely combinational redstone comparator arithmetic.
//   mode  : in  - 0 = compare, 1 = subtract
//   back  : in  - rear input strength
//   lside : in  - left side strength
//   rside : in  - right side strength
//   front : out - resulting front strength
//
// The effective side strength is the larger of the two side inputs.
// Subtract mode never wraps: a side stronger than the back yields 0.
// Compare mode passes the back strength through only when it is not
// weaker than the side.
// -----------------------------------------------------------------------------
module comparator_core
    import comparator_arbiter_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] back,
    input  logic [3:0] lside,
    input  logic [3:0] rside,
    output logic [3:0] front
);

    // Difference is formed one bit wider and signed so a negative result is
    // visible and clamped instead of wrapping around to a large strength.
    function automatic strength_t sat_sub(input strength_t a, input strength_t b);
        logic signed [4:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return (diff < 0) ? 4'd0 : diff[3:0];
    endfunction

    function automatic strength_t compare_sel(input strength_t a, input strength_t b);
        return (a >= b) ? a : 4'd0;
    endfunction

    strength_t side;

    always_comb begin
        side = strength_max(lside, rside);
        if (mode == MODE_SUBTRACT) begin
            front = sat_sub(back, side);
        end else begin
            front = compare_sel(back, side);
        end
    end

endmodule

// File: rtl/comparator_arbiter.sv
// -----------------------------------------------------------------------------
// comparator_arbiter
//
// Round-robin arbiter sharing one comparator_core between NREQ requesters.
// One operation is in flight at a time: a requester is granted in IDLE, its
// operands are captured, the operation occupies the unit for OP_TICKS cycles,
// and the result is then presented with a valid/ready handshake.
//
// Parameters
//   NREQ     - number of requesters (2..8)
//   OP_TICKS - busy cycles per operation (1..15)
//
// Ports
//   clk       : in  - clock, rising edge
//   reset_n   : in  - asynchronous active-low reset
//   req       : in  - per-requester request, held until granted
//   mode      : in  - per-requester mode (0 compare, 1 subtract)
//   back      : in  - per-requester back strength, 4 bits each
//   lside     : in  - per-requester left side strength, 4 bits each
//   rside     : in  - per-requester right side strength, 4 bits each
//   gnt       : out - one-hot grant, high only in the acceptance cycle
//   rsp_valid : out - result available
//   rsp_ready : in  - consumer accepts the result
//   rsp_id    : out - index of the requester owning the result
//   rsp_front : out - comparator front strength
//
// Timing: grant in cycle T, BUSY for OP_TICKS cycles, rsp_valid first high in
// cycle T+OP_TICKS+1. With rsp_ready held high a new grant can follow every
// OP_TICKS+2 cycles.
// -----------------------------------------------------------------------------
module comparator_arbiter
    import comparator_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int OP_TICKS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   mode,
    input  logic [NREQ*4-1:0] back,
    input  logic [NREQ*4-1:0] lside,
    input  logic [NREQ*4-1:0] rside,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_id,
    output logic [3:0]        rsp_front
);

    localparam logic [3:0] CNT_LOAD = 4'(OP_TICKS - 1);
    localparam logic [2:0] LAST_ID  = 3'(NREQ - 1);

    state_t     state;
    logic [2:0] rr_ptr;
    logic [3:0] busy_cnt;

    // Round-robin search results
    logic [2:0] winner;
    logic [2:0] low_any;
    logic [2:0] low_hi;
    logic       found_any;
    logic       found_hi;
    logic [2:0] next_ptr;
    logic       launch;

    // Winner's operands, selected combinationally for capture
    logic      sel_mode;
    strength_t sel_back;
    strength_t sel_lside;
    strength_t sel_rside;

    // Captured operands of the in-flight operation
    logic       mode_p0;
    logic [2:0] id_p0;
    strength_t  back_p0;
    strength_t  lside_p0;
    strength_t  rside_p0;

    strength_t  core_front;

    // ---- arbitration: rotating priority starting at rr_ptr ----
    // The first set bit at or above rr_ptr wins; if none exists the search
    // wraps, which is the same as taking the lowest set bit overall. Scanning
    // downward lets the last assignment be the lowest matching index.
    always_comb begin
        low_any   = '0;
        low_hi    = '0;
        found_any = 1'b0;
        found_hi  = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                low_any   = 3'(j);
                found_any = 1'b1;
                if (3'(j) >= rr_ptr) begin
                    low_hi   = 3'(j);
                    found_hi = 1'b1;
                end
            end
        end
        winner   = found_hi ? low_hi : low_any;
        next_ptr = (winner == LAST_ID) ? 3'd0 : winner + 3'd1;
    end

    assign launch = (state == ST_IDLE) && found_any;

    // Grant is combinational from req so the requester sees it in the same
    // cycle; it is also forced low while reset is asserted, since the state
    // register already reads IDLE during reset.
    always_comb begin
        gnt = '0;
        for (int j = 0; j < NREQ; j++) begin
            gnt[j] = reset_n && launch && (winner == 3'(j));
        end
    end

    always_comb begin
        sel_mode  = 1'b0;
        sel_back  = '0;
        sel_lside = '0;
        sel_rside = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (winner == 3'(j)) begin
                sel_mode  = mode[j];
                sel_back  = back[j*4 +: 4];
                sel_lside = lside[j*4 +: 4];
                sel_rside = rside[j*4 +: 4];
            end
        end
    end

    // ---- stage p0: operand capture at the end of the grant cycle ----
    // Held for the whole operation so later changes on the request-side
    // operand inputs cannot disturb the in-flight result.
    always_ff @(posedge clk) begin
        if (launch) begin
            id_p0    <= winner;
            mode_p0  <= sel_mode;
            back_p0  <= sel_back;
            lside_p0 <= sel_lside;
            rside_p0 <= sel_rside;
        end
    end

    comparator_core u_core (
        .mode  (mode_p0),
        .back  (back_p0),
        .lside (lside_p0),
        .rside (rside_p0),
        .front (core_front)
    );

    // ---- stage p1: sequencing and registered response ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            busy_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_front <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (launch) begin
                        rr_ptr   <= next_ptr;
                        busy_cnt <= CNT_LOAD;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (busy_cnt == 4'd0) begin
                        rsp_front <= core_front;
                        rsp_id    <= id_p0;
                        rsp_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        busy_cnt <= busy_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    // id/front keep their values; only valid drops on accept
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_arbiter.sv
module tb_comparator_arbiter;

    localparam int NREQ     = 4;
    localparam int OP_TICKS = 2;
    localparam int PERIOD   = OP_TICKS + 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   mode = '0;
    logic [NREQ*4-1:0] back = '0;
    logic [NREQ*4-1:0] lside = '0;
    logic [NREQ*4-1:0] rside = '0;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [2:0]        rsp_id;
    logic [3:0]        rsp_front;

    int vectors     = 0;
    int miscompares = 0;
    int model_rr    = 0;

    comparator_arbiter #(.NREQ(NREQ), .OP_TICKS(OP_TICKS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .mode      (mode),
        .back      (back),
        .lside     (lside),
        .rside     (rside),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_front (rsp_front)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected normal finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] model_front(input logic m, input int b, input int l, input int r);
        int side;
        int res;
        side = (l > r) ? l : r;
        if (m) res = (b - side < 0) ? 0 : b - side;
        else   res = (b >= side) ? b : 0;
        return 4'(res);
    endfunction

    function automatic int model_winner(input logic [NREQ-1:0] r, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] model_of(input int i);
        return model_front(mode[i], int'(back[i*4 +: 4]), int'(lside[i*4 +: 4]), int'(rside[i*4 +: 4]));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic m, input logic [3:0] b, input logic [3:0] l, input logic [3:0] r);
        mode[i]         = m;
        back[i*4 +: 4]  = b;
        lside[i*4 +: 4] = l;
        rside[i*4 +: 4] = r;
    endtask

    task automatic randomize_ops();
        mode  = NREQ'($urandom);
        back  = (NREQ*4)'($urandom);
        lside = (NREQ*4)'($urandom);
        rside = (NREQ*4)'($urandom);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req       = '0;
        rsp_ready = 1'b0;
        mode      = '0;
        back      = '0;
        lside     = '0;
        rside     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        model_rr = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        req     = '1;
        #2;
        vectors++;
        if (gnt !== '0 || rsp_valid !== 1'b0 || rsp_id !== 3'd0 || rsp_front !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got gnt=%b valid=%b id=%0d front=%0d, expected all zero", gnt, rsp_valid, rsp_id, rsp_front);
        end
        next_cycle();
        #2;
        vectors++;
        if (gnt !== '0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got gnt=%b valid=%b, expected 0000/0", gnt, rsp_valid);
        end
        reset_n = 1'b1;
        #2;
        vectors++;
        if (gnt !== onehot(model_winner(req, 0))) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b expected %b", gnt, onehot(model_winner(req, 0)));
        end
        do_reset();
    endtask

    task automatic test_subtract_sat();
        do_reset();
        set_op(0, 1'b1, 4'd5, 4'd9, 4'd3);
        req = 4'b0001;
        #2;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL sat_gnt: got %b expected 0001", gnt);
        end
        next_cycle();
        req = '0;
        for (int c = 1; c <= OP_TICKS + 1; c++) begin
            #2;
            vectors++;
            if (rsp_valid !== (c == OP_TICKS + 1)) begin
                miscompares++;
                $display("FAIL sat_latency: cycle +%0d got valid=%b expected %b", c, rsp_valid, (c == OP_TICKS + 1));
            end
            if (c == OP_TICKS + 1) begin
                vectors++;
                if (rsp_front !== 4'd0 || rsp_id !== 3'd0) begin
                    miscompares++;
                    $display("FAIL sat_result: got front=%0d id=%0d expected front=0 id=0", rsp_front, rsp_id);
                end
                rsp_ready = 1'b1;
            end
            next_cycle();
        end
        rsp_ready = 1'b0;
        #2;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_release: got valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_compare();
        logic [3:0] exp_front;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_op(2, 1'b0, 4'd12, 4'd7, (k == 0) ? 4'd12 : 4'd13);
            exp_front = (k == 0) ? 4'd12 : 4'd0;
            req = 4'b0100;
            #2;
            vectors++;
            if (gnt !== 4'b0100) begin
                miscompares++;
                $display("FAIL cmp_gnt%0d: got %b expected 0100", k, gnt);
            end
            next_cycle();
            req = '0;
            repeat (OP_TICKS) next_cycle();
            #2;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_front !== exp_front || rsp_id !== 3'd2) begin
                miscompares++;
                $display("FAIL cmp_result%0d: got valid=%b front=%0d id=%0d expected 1/%0d/2", k, rsp_valid, rsp_front, rsp_id, exp_front);
            end
            rsp_ready = 1'b1;
            next_cycle();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_gnt;
        int k;
        int ph;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, i[0], 4'(4 + 3 * i), 4'(i), 4'(2 * i));
        req       = '1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 5 * PERIOD; cyc++) begin
            k  = cyc / PERIOD;
            ph = cyc % PERIOD;
            exp_gnt = (ph == 0) ? onehot(k % NREQ) : '0;
            #2;
            vectors++;
            if (gnt !== exp_gnt) begin
                miscompares++;
                $display("FAIL rr_gnt: cycle %0d got %b expected %b", cyc, gnt, exp_gnt);
            end
            if (ph == OP_TICKS + 1) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_id !== 3'(k % NREQ) || rsp_front !== model_of(k % NREQ)) begin
                    miscompares++;
                    $display("FAIL rr_rsp: cycle %0d got valid=%b id=%0d front=%0d expected 1/%0d/%0d",
                             cyc, rsp_valid, rsp_id, rsp_front, k % NREQ, model_of(k % NREQ));
                end
            end
            next_cycle();
        end
        req       = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_op(0, 1'b1, 4'd9, 4'd2, 4'd4);
        req = 4'b0001;
        next_cycle();
        model_rr = 1;
        req = '0;
        repeat (OP_TICKS) next_cycle();
        req       = 4'b0110;
        rsp_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #2;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_front !== 4'd5 || gnt !== '0) begin
                miscompares++;
                $display("FAIL bp_stall: cycle %0d got valid=%b id=%0d front=%0d gnt=%b expected 1/0/5/0000",
                         s, rsp_valid, rsp_id, rsp_front, gnt);
            end
            next_cycle();
        end
        rsp_ready = 1'b1;
        next_cycle();
        rsp_ready = 1'b0;
        #2;
        vectors++;
        if (gnt !== onehot(model_winner(req, model_rr))) begin
            miscompares++;
            $display("FAIL bp_next_gnt: got %b expected %b", gnt, onehot(model_winner(req, model_rr)));
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_op(3, 1'b1, 4'd9, 4'd2, 4'd1);
        req = 4'b1000;
        next_cycle();
        req = '0;
        repeat (OP_TICKS) next_cycle();
        #2;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 3'd3 || rsp_front !== 4'd7) begin
            miscompares++;
            $display("FAIL mr_first: got valid=%b id=%0d front=%0d expected 1/3/7", rsp_valid, rsp_id, rsp_front);
        end
        rsp_ready = 1'b1;
        next_cycle();
        rsp_ready = 1'b0;
        set_op(0, 1'b0, 4'd15, 4'd1, 4'd1);
        req = 4'b0001;
        next_cycle();
        req = 4'b1010;
        #2;
        vectors++;
        if (gnt !== '0) begin
            miscompares++;
            $display("FAIL mr_busy_gnt: got %b expected 0000", gnt);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (gnt !== '0 || rsp_valid !== 1'b0 || rsp_id !== 3'd0 || rsp_front !== 4'd0) begin
            miscompares++;
            $display("FAIL mr_async: got gnt=%b valid=%b id=%0d front=%0d expected all zero", gnt, rsp_valid, rsp_id, rsp_front);
        end
        reset_n = 1'b1;
        #1;
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL mr_after: got %b expected 0010", gnt);
        end
    endtask

    task automatic test_operand_change();
        do_reset();
        set_op(1, 1'b1, 4'd15, 4'd4, 4'd4);
        req = 4'b0010;
        #2;
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL opchg_gnt: got %b expected 0010", gnt);
        end
        next_cycle();
        req = '0;
        set_op(1, 1'b0, 4'd0, 4'd15, 4'd15);
        repeat (OP_TICKS) next_cycle();
        #2;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_front !== 4'd11 || rsp_id !== 3'd1) begin
            miscompares++;
            $display("FAIL opchg_result: got valid=%b front=%0d id=%0d expected 1/11/1", rsp_valid, rsp_front, rsp_id);
        end
        rsp_ready = 1'b1;
        next_cycle();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r;
        logic [3:0]      ef;
        int              w;
        int              stall;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = '0;
                randomize_ops();
                #2;
                vectors++;
                if (gnt !== '0) begin
                    miscompares++;
                    $display("FAIL rnd_idle: iter %0d got %b expected 0000", n, gnt);
                end
                next_cycle();
            end
            randomize_ops();
            r   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req = r;
            w   = model_winner(r, model_rr);
            ef  = model_of(w);
            #2;
            vectors++;
            if (gnt !== onehot(w)) begin
                miscompares++;
                $display("FAIL rnd_gnt: iter %0d req=%b got %b expected %b", n, r, gnt, onehot(w));
            end
            next_cycle();
            model_rr = (w + 1) % NREQ;
            for (int c = 1; c <= OP_TICKS; c++) begin
                req = NREQ'($urandom);
                randomize_ops();
                #2;
                vectors++;
                if (gnt !== '0 || rsp_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_busy: iter %0d got gnt=%b valid=%b expected 0000/0", n, gnt, rsp_valid);
                end
                next_cycle();
            end
            stall = int'($urandom_range(0, 2));
            for (int s = 0; s <= stall; s++) begin
                req       = NREQ'($urandom);
                rsp_ready = (s == stall);
                #2;
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_id !== 3'(w) || rsp_front !== ef || gnt !== '0) begin
                    miscompares++;
                    $display("FAIL rnd_rsp: iter %0d got valid=%b id=%0d front=%0d gnt=%b expected 1/%0d/%0d/0000",
                             n, rsp_valid, rsp_id, rsp_front, gnt, w, ef);
                end
                next_cycle();
            end
            rsp_ready = 1'b0;
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_subtract_sat();
        test_compare();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
        test_operand_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/comparator_arbiter.md
COMPARATOR_ARBITER -- requirements
Module: comparator_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one comparator unit (2..8).
REQ-002 The block SHALL have parameter OP_TICKS, default 2, meaning the busy cycles per operation (1..15), equal to one redstone tick.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, NREQ bits: per-requester request, held high until granted.
REQ-006 The block SHALL have port mode, input, NREQ bits: per-requester mode; 0 = compare, 1 = subtract.
REQ-007 The block SHALL have port back, input, NREQ x 4 bits: per-requester back strength.
REQ-008 The block SHALL have port lside, input, NREQ x 4 bits: per-requester left side strength.
REQ-009 The block SHALL have port rside, input, NREQ x 4 bits: per-requester right side strength.
REQ-010 The block SHALL have port gnt, output, NREQ bits: one-hot grant, high for exactly the acceptance cycle.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have port rsp_id, output, 3 bits: index of the requester owning the result.
REQ-014 The block SHALL have port rsp_front, output, 4 bits: comparator front strength.

Function
REQ-015 The FSM SHALL have three states, IDLE, BUSY and DONE, with reset state IDLE.
REQ-016 In IDLE with any req bit high, the block SHALL assert gnt combinationally for the winner only.
- The winner is the first set req bit at or after rr_ptr, searching upward with wrap-around.
REQ-017 At the end of a grant cycle, the block SHALL capture the winner's mode, back, lside and rside.
- It SHALL load busy counter = OP_TICKS-1 and enter BUSY.
REQ-018 In BUSY the counter SHALL decrement each cycle; at count 0 the block SHALL register the result and enter DONE.
REQ-019 Side strength SHALL be max(lside, rside).
REQ-020 In subtract mode, front SHALL be back - side, saturated at 0; it SHALL never wrap.
REQ-021 In compare mode, front SHALL be back if back >= side, else 0.
REQ-022 In DONE, rsp_valid SHALL be 1, and rsp_id/rsp_front SHALL be held stable until rsp_ready is sampled high.
- The block then enters IDLE on the next cycle.
REQ-023 The first rsp_valid cycle SHALL occur exactly OP_TICKS+1 cycles after the grant cycle.
REQ-024 rr_ptr SHALL update to (winner+1) mod NREQ in the grant cycle only, giving round-robin fairness.
- No requester waits more than NREQ-1 foreign grants.
REQ-025 gnt SHALL be all-zero in BUSY and DONE, even if req bits are high.
REQ-026 A req bit dropping before its grant SHALL withdraw the request with no side effect.
REQ-027 Operand changes after the grant cycle SHALL NOT affect the in-flight result.
REQ-028 With rsp_ready held high, back-to-back operations SHALL complete one every OP_TICKS+2 cycles.

Reset
REQ-029 While reset_n is low, the block SHALL force state=IDLE, rr_ptr=0, counter=0, gnt=0, rsp_valid=0, rsp_id=0 and rsp_front=0.
- Reset is asynchronous and applies mid-operation; in-flight results are discarded.
REQ-030 After reset_n rises, the first grant SHALL favour requester 0.

Structure
REQ-031 A shared package SHALL hold:
- the 4-bit redstone strength typedef;
- the mode encoding constants (COMPARE=0, SUBTRACT=1);
- the FSM state enum.
REQ-032 The strength arithmetic (max of sides, saturating subtract, compare select) SHALL be one combinational sub-module, comparator_core, instantiated once.
- The arbiter, FSM and counter SHALL stay in comparator_arbiter.

Verification
REQ-033 Subtract saturation: req[0], subtract, back=5, lside=9, rside=3 -> gnt=0001; rsp_valid 3 cycles later with rsp_front=0, rsp_id=0.
REQ-034 Compare mode: req[2], compare, back=12, lside=7, rside=12 -> rsp_front=12; repeat with rside=13 -> rsp_front=0.
REQ-035 Round-robin: req=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; one grant every 4 cycles (OP_TICKS=2).
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_id and rsp_front stable; gnt stays 0 despite req=0110.
REQ-037 Mid-operation reset: reset_n pulled low during BUSY -> all outputs 0 immediately; after release, req=1010 -> gnt=0010.
REQ-038 Operand change after grant: back changes from 15 to 0 one cycle after gnt, subtract, sides 4 -> rsp_front=11.
